// File: rtl/sw_affine_array.sv
// sw_affine_array
// Smith-Waterman local aligner with affine gap penalties on an N_PE-wide
// systolic array. Both symbol streams are captured into local memories, then
// the query is walked in stripes of N_PE columns. Each PE owns one query
// column of the current stripe and sweeps down the reference one row per
// cycle, skewed by one cycle per PE. The bottom PE's H/D column is parked in
// a LEN_REF-deep buffer and feeds PE 0 during the next stripe.
//
// Ports
//   clk        : clock, everything on the rising edge
//   reset      : synchronous, active-low; aborts any job in progress
//   valid      : a symbol pair is present on data_ref/data_query
//   data_ref   : 2-bit reference symbol
//   data_query : 2-bit query symbol
//   ready      : symbols are accepted (IDLE/LOAD)
//   finish     : one-cycle pulse, results valid in the same cycle
//   max        : best local score (unsigned)
//   pos_ref    : 1-based reference index of the best cell (0 if none)
//   pos_query  : 1-based query index of the best cell (0 if none)
module sw_affine_array #(
  parameter int WIDTH_SCORE     = 8,
  parameter int WIDTH_POS_REF   = 7,
  parameter int WIDTH_POS_QUERY = 6,
  parameter int LEN_REF         = 64,
  parameter int LEN_QUERY       = 48,
  parameter int N_PE            = 4,
  parameter int MATCH           = 2,
  parameter int MISMATCH        = -1,
  parameter int G_OPEN          = 2,
  parameter int G_EXTEND        = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       valid,
  input  logic [1:0]                 data_ref,
  input  logic [1:0]                 data_query,
  output logic                       ready,
  output logic                       finish,
  output logic [WIDTH_SCORE-1:0]     max,
  output logic [WIDTH_POS_REF-1:0]   pos_ref,
  output logic [WIDTH_POS_QUERY-1:0] pos_query
);

  localparam int SW       = WIDTH_SCORE + 2;
  localparam int L_MAX    = (LEN_REF > LEN_QUERY) ? LEN_REF : LEN_QUERY;
  localparam int N_STRIPE = LEN_QUERY / N_PE;
  localparam int C_LEN    = LEN_REF + N_PE - 1;
  localparam int LW       = $clog2(L_MAX + 1);
  localparam int CW       = $clog2(C_LEN + 1);
  localparam int STW      = $clog2(N_STRIPE + 1);
  localparam int RA_W     = (LEN_REF > 1) ? $clog2(LEN_REF) : 1;
  localparam int QA_W     = (LEN_QUERY > 1) ? $clog2(LEN_QUERY) : 1;

  localparam logic signed [SW-1:0] K_MATCH    = SW'(MATCH);
  localparam logic signed [SW-1:0] K_MISMATCH = SW'(MISMATCH);
  localparam logic signed [SW-1:0] K_OPEN     = SW'(G_OPEN);
  localparam logic signed [SW-1:0] K_EXT      = SW'(G_EXTEND);
  localparam logic signed [SW-1:0] K_NEG_OPEN = SW'(-G_OPEN);
  localparam logic signed [SW-1:0] K_ZERO     = '0;

  typedef enum logic [1:0] {IDLE, LOAD, CAL, DONE} state_t;

  state_t state_q, state_d;

  logic [LW-1:0]  load_cnt_q;
  logic [CW-1:0]  cyc_q;
  logic [STW-1:0] stripe_q;
  logic           xfer;
  logic           last_cyc;
  logic           last_stripe;

  logic [1:0] ref_mem [LEN_REF];
  logic [1:0] qry_mem [LEN_QUERY];

  logic signed [SW-1:0] buf_h [LEN_REF];
  logic signed [SW-1:0] buf_d [LEN_REF];

  // Per-PE registered state: own previous H and I (the cell above), the
  // last D handed to the right neighbour, and the delayed left H (diagonal).
  logic signed [SW-1:0] h_q    [N_PE];
  logic signed [SW-1:0] i_q    [N_PE];
  logic signed [SW-1:0] d_q    [N_PE];
  logic signed [SW-1:0] diag_q [N_PE];

  logic [N_PE-1:0]             pe_act;
  logic [1:0]                  pe_ref   [N_PE];
  logic [1:0]                  pe_qry   [N_PE];
  logic [WIDTH_POS_REF-1:0]    pe_i     [N_PE];
  logic [WIDTH_POS_QUERY-1:0]  pe_j     [N_PE];
  logic signed [SW-1:0]        left_h   [N_PE];
  logic signed [SW-1:0]        left_d   [N_PE];
  logic signed [SW-1:0]        sub_s    [N_PE];
  logic signed [SW-1:0]        i_new    [N_PE];
  logic signed [SW-1:0]        d_new    [N_PE];
  logic signed [SW-1:0]        h_new    [N_PE];

  logic [WIDTH_SCORE-1:0]      best_h_q, fold_h;
  logic [WIDTH_POS_REF-1:0]    best_i_q, fold_i;
  logic [WIDTH_POS_QUERY-1:0]  best_j_q, fold_j;

  function automatic logic signed [SW-1:0] smax(input logic signed [SW-1:0] a,
                                                input logic signed [SW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  assign xfer        = valid && ready && reset;
  assign last_cyc    = (cyc_q == CW'(C_LEN - 1));
  assign last_stripe = (stripe_q == STW'(N_STRIPE - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (xfer) state_d = (load_cnt_q == LW'(L_MAX - 1)) ? CAL : LOAD;
      LOAD: if (xfer && (load_cnt_q == LW'(L_MAX - 1))) state_d = CAL;
      CAL:  if (last_cyc && last_stripe) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ready is registered; it stays low in the cycle where finish is pulsed so
  // the next job can start at the earliest one edge after the pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      load_cnt_q <= '0;
      cyc_q      <= '0;
      stripe_q   <= '0;
      ready      <= 1'b0;
    end else begin
      state_q <= state_d;
      ready   <= ((state_d == IDLE) || (state_d == LOAD)) && (state_q != DONE);
      if (state_q == CAL) begin
        if (last_cyc) begin
          cyc_q    <= '0;
          stripe_q <= last_stripe ? '0 : stripe_q + 1'b1;
        end else begin
          cyc_q <= cyc_q + 1'b1;
        end
      end else begin
        cyc_q    <= '0;
        stripe_q <= '0;
      end
      if ((state_q == CAL) || (state_q == DONE)) begin
        load_cnt_q <= '0;
      end else if (xfer) begin
        load_cnt_q <= load_cnt_q + 1'b1;
      end
    end
  end

  // Symbol capture: the shorter stream simply stops being written once its
  // length is reached while the longer one keeps loading.
  always_ff @(posedge clk) begin
    if (xfer) begin
      if (load_cnt_q < LW'(LEN_REF))   ref_mem[RA_W'(load_cnt_q)] <= data_ref;
      if (load_cnt_q < LW'(LEN_QUERY)) qry_mem[QA_W'(load_cnt_q)] <= data_query;
    end
  end

  // PE p in cycle c works on row i = c - p + 1 of column stripe*N_PE + p + 1.
  always_comb begin
    for (int p = 0; p < N_PE; p++) begin
      pe_act[p] = (int'(cyc_q) >= p) && ((int'(cyc_q) - p) < LEN_REF);
      pe_ref[p] = pe_act[p] ? ref_mem[RA_W'(int'(cyc_q) - p)] : 2'b00;
      pe_qry[p] = qry_mem[QA_W'(int'(stripe_q) * N_PE + p)];
      pe_i[p]   = WIDTH_POS_REF'(int'(cyc_q) - p + 1);
      pe_j[p]   = WIDTH_POS_QUERY'(int'(stripe_q) * N_PE + p + 1);
    end
  end

  // PE 0 takes its left column from the stripe buffer, or from the H=0 /
  // D=-G_OPEN boundary in the first stripe. Other PEs take their neighbour.
  always_comb begin
    left_h[0] = (stripe_q == '0) ? K_ZERO : buf_h[RA_W'(cyc_q)];
    left_d[0] = (stripe_q == '0) ? K_NEG_OPEN : buf_d[RA_W'(cyc_q)];
    for (int p = 1; p < N_PE; p++) begin
      left_h[p] = h_q[p-1];
      left_d[p] = d_q[p-1];
    end
  end

  always_comb begin
    for (int p = 0; p < N_PE; p++) begin
      sub_s[p] = (pe_ref[p] == pe_qry[p]) ? K_MATCH : K_MISMATCH;
      i_new[p] = smax(h_q[p] - K_OPEN, i_q[p] - K_EXT);
      d_new[p] = smax(left_h[p] - K_OPEN, left_d[p] - K_EXT);
      h_new[p] = smax(smax(diag_q[p] + sub_s[p], i_new[p]), smax(d_new[p], K_ZERO));
    end
  end

  // PE state returns to the row-0 boundary at every stripe start and whenever
  // no computation is running, so nothing leaks between stripes or jobs.
  always_ff @(posedge clk) begin
    if (!reset || (state_q != CAL) || last_cyc) begin
      for (int p = 0; p < N_PE; p++) begin
        h_q[p]    <= K_ZERO;
        i_q[p]    <= K_NEG_OPEN;
        d_q[p]    <= K_NEG_OPEN;
        diag_q[p] <= K_ZERO;
      end
    end else begin
      for (int p = 0; p < N_PE; p++) begin
        diag_q[p] <= left_h[p];
        if (pe_act[p]) begin
          h_q[p] <= h_new[p];
          i_q[p] <= i_new[p];
          d_q[p] <= d_new[p];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if ((state_q == CAL) && pe_act[N_PE-1]) begin
      buf_h[RA_W'(int'(cyc_q) - (N_PE - 1))] <= h_new[N_PE-1];
      buf_d[RA_W'(int'(cyc_q) - (N_PE - 1))] <= d_new[N_PE-1];
    end
  end

  // Cells reach the tracker out of row order (later stripes revisit low
  // rows), so the tie-break compares positions explicitly. Zero scores never
  // win, which leaves the position at 0 when nothing scores.
  always_comb begin
    fold_h = best_h_q;
    fold_i = best_i_q;
    fold_j = best_j_q;
    for (int p = 0; p < N_PE; p++) begin
      if ((state_q == CAL) && pe_act[p] && (h_new[p] > K_ZERO) &&
          ((h_new[p] > $signed({2'b00, fold_h})) ||
           ((h_new[p] == $signed({2'b00, fold_h})) &&
            ((pe_i[p] < fold_i) || ((pe_i[p] == fold_i) && (pe_j[p] < fold_j)))))) begin
        fold_h = h_new[p][WIDTH_SCORE-1:0];
        fold_i = pe_i[p];
        fold_j = pe_j[p];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || (state_q != CAL)) begin
      best_h_q <= '0;
      best_i_q <= '0;
      best_j_q <= '0;
    end else begin
      best_h_q <= fold_h;
      best_i_q <= fold_i;
      best_j_q <= fold_j;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      finish    <= 1'b0;
      max       <= '0;
      pos_ref   <= '0;
      pos_query <= '0;
    end else begin
      finish <= (state_q == DONE);
      if (state_q == DONE) begin
        max       <= best_h_q;
        pos_ref   <= best_i_q;
        pos_query <= best_j_q;
      end
    end
  end

endmodule

// File: tb/tb_sw_affine_array.sv
// tb_sw_affine_array
// Directed bench for sw_affine_array: a default-parameter instance and a
// small affine-gap instance (8x6, 3 PEs). Expected scores and positions are
// hand-derived constants for each scenario.
module tb_sw_affine_array;

  localparam int T_CAL0 = 804;
  localparam int T_CAL1 = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       valid0, valid1;
  logic [1:0] dr0, dq0, dr1, dq1;
  logic       ready0, ready1, finish0, finish1;
  logic [7:0] max0, max1;
  logic [6:0] pr0;
  logic [5:0] pq0;
  logic [3:0] pr1;
  logic [2:0] pq1;

  sw_affine_array u_dut (
    .clk(clk), .reset(reset), .valid(valid0), .data_ref(dr0), .data_query(dq0),
    .ready(ready0), .finish(finish0), .max(max0), .pos_ref(pr0), .pos_query(pq0)
  );

  sw_affine_array #(
    .LEN_REF(8), .LEN_QUERY(6), .N_PE(3), .WIDTH_POS_REF(4), .WIDTH_POS_QUERY(3)
  ) u_aff (
    .clk(clk), .reset(reset), .valid(valid1), .data_ref(dr1), .data_query(dq1),
    .ready(ready1), .finish(finish1), .max(max1), .pos_ref(pr1), .pos_query(pq1)
  );

  logic       sel;
  logic       drv_valid;
  logic       m_ready, m_finish;
  logic [7:0] m_max, m_pr, m_pq;
  logic [1:0] ref_vec [64];
  logic [1:0] qry_vec [48];
  int         vec_count = 0;
  int         fail_count = 0;
  int         cyc_count = 0;

  always @(posedge clk) cyc_count <= cyc_count + 1;

  always_comb begin
    m_ready  = sel ? ready1 : ready0;
    m_finish = sel ? finish1 : finish0;
    m_max    = sel ? max1 : max0;
    m_pr     = sel ? {4'b0, pr1} : {1'b0, pr0};
    m_pq     = sel ? {5'b0, pq1} : {2'b0, pq0};
  end

  task automatic checkOutput(input string tag, input int got, input int exp);
    vec_count++;
    if (got != exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] r, input logic [1:0] q);
    drv_valid = v;
    if (sel) begin
      valid1 = v; dr1 = r; dq1 = q;
    end else begin
      valid0 = v; dr0 = r; dq0 = q;
    end
  endtask

  task automatic fillVectors(input int scen);
    for (int i = 0; i < 64; i++) ref_vec[i] = 2'd0;
    for (int i = 0; i < 48; i++) qry_vec[i] = (scen == 1) ? 2'd0 : 2'd1;
    if (scen == 3) begin
      ref_vec[9] = 2'd3;
      qry_vec[4] = 2'd3;
    end
    if (scen == 4) begin
      ref_vec[0] = 2'd0; ref_vec[1] = 2'd1; ref_vec[2] = 2'd2; ref_vec[3] = 2'd2;
      ref_vec[4] = 2'd3; ref_vec[5] = 2'd0; ref_vec[6] = 2'd1; ref_vec[7] = 2'd0;
      qry_vec[0] = 2'd0; qry_vec[1] = 2'd1; qry_vec[2] = 2'd2;
      qry_vec[3] = 2'd3; qry_vec[4] = 2'd0; qry_vec[5] = 2'd1;
    end
  endtask

  // Loads one job into the selected instance and optionally waits for finish.
  task automatic applyStimulus(input bit gaps, input bit junk, input bit wait_done,
                               output int lat, output int first_cyc, output int held_max);
    int  n, lr, lq, tcal, k, guard, cnt;
    bit  rdy, ready_seen;
    n = sel ? 8 : 64; lr = sel ? 8 : 64; lq = sel ? 6 : 48;
    tcal = sel ? T_CAL1 : T_CAL0;
    k = 0; guard = 0; lat = -1; first_cyc = -1;
    while (k < n && guard < 4 * n + 20) begin
      @(negedge clk);
      if (gaps && $urandom_range(0, 9) < 3)
        drive(1'b0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      else
        drive(1'b1, (k < lr) ? ref_vec[k] : 2'($urandom_range(0, 3)),
                    (k < lq) ? qry_vec[k] : 2'($urandom_range(0, 3)));
      rdy = m_ready;
      @(posedge clk); #1;
      if (drv_valid && rdy) begin
        if (k == 0) first_cyc = cyc_count;
        k++;
      end
      guard++;
    end
    checkOutput("load_count", k, n);
    held_max = int'(m_max);
    drive(junk, 2'd3, 2'd3);
    if (wait_done) begin
      cnt = 0; ready_seen = 1'b0;
      while (!m_finish && cnt < tcal + 20) begin
        @(posedge clk); #1;
        cnt++;
        if (m_ready) ready_seen = 1'b1;
      end
      drive(1'b0, 2'd0, 2'd0);
      if (m_finish) lat = cnt;
      checkOutput("finish_seen", int'(m_finish), 1);
      checkOutput("ready_low_cal", int'(ready_seen), 0);
    end else begin
      drive(1'b0, 2'd0, 2'd0);
    end
  endtask

  initial begin
    int lat, f1, f2, held;
    reset = 1'b0; sel = 1'b0;
    valid0 = 1'b0; dr0 = 2'd0; dq0 = 2'd0;
    valid1 = 1'b0; dr1 = 2'd0; dq1 = 2'd0;
    drv_valid = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_ready", int'(ready0), 0);
    checkOutput("rst_ready_aff", int'(ready1), 0);
    checkOutput("rst_finish", int'(finish0), 0);
    checkOutput("rst_max", int'(max0), 0);
    checkOutput("rst_pos_ref", int'(pr0), 0);
    checkOutput("rst_pos_query", int'(pq0), 0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("ready_after_reset", int'(ready0), 1);

    $display("[TB] scenario: ref 0s, query 1s");
    fillVectors(2);
    applyStimulus(1'b0, 1'b0, 1'b1, lat, f1, held);
    checkOutput("nomatch_max", int'(m_max), 0);
    checkOutput("nomatch_pos_ref", int'(m_pr), 0);
    checkOutput("nomatch_pos_query", int'(m_pq), 0);

    $display("[TB] scenario: all zeros");
    fillVectors(1);
    applyStimulus(1'b0, 1'b0, 1'b1, lat, f1, held);
    checkOutput("zeros_max", int'(m_max), 96);
    checkOutput("zeros_pos_ref", int'(m_pr), 48);
    checkOutput("zeros_pos_query", int'(m_pq), 48);
    checkOutput("zeros_latency", lat, T_CAL0 + 1);
    @(posedge clk); #1;
    checkOutput("finish_one_cycle", int'(m_finish), 0);
    checkOutput("ready_back", int'(m_ready), 1);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("max_hold", int'(m_max), 96);

    $display("[TB] scenario: single match, gaps and junk valid");
    fillVectors(3);
    applyStimulus(1'b1, 1'b1, 1'b1, lat, f1, held);
    checkOutput("held_prev_max", held, 96);
    checkOutput("single_max", int'(m_max), 2);
    checkOutput("single_pos_ref", int'(m_pr), 10);
    checkOutput("single_pos_query", int'(m_pq), 5);

    $display("[TB] scenario: affine gap instance");
    sel = 1'b1;
    fillVectors(4);
    applyStimulus(1'b0, 1'b0, 1'b1, lat, f1, held);
    checkOutput("aff_max", int'(m_max), 10);
    checkOutput("aff_pos_ref", int'(m_pr), 7);
    checkOutput("aff_pos_query", int'(m_pq), 6);
    checkOutput("aff_latency", lat, T_CAL1 + 1);
    applyStimulus(1'b1, 1'b1, 1'b1, lat, f1, held);
    checkOutput("aff_gap_max", int'(m_max), 10);
    checkOutput("aff_gap_pos_ref", int'(m_pr), 7);
    checkOutput("aff_gap_pos_query", int'(m_pq), 6);

    $display("[TB] scenario: reset mid-computation");
    sel = 1'b0;
    fillVectors(1);
    applyStimulus(1'b0, 1'b0, 1'b0, lat, f1, held);
    checkOutput("held_before_abort", held, 2);
    repeat (100) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("abort_max", int'(max0), 0);
    checkOutput("abort_pos_ref", int'(pr0), 0);
    checkOutput("abort_pos_query", int'(pq0), 0);
    checkOutput("abort_finish", int'(finish0), 0);
    checkOutput("abort_ready", int'(ready0), 0);
    @(negedge clk) reset = 1'b1;

    $display("[TB] scenario: back-to-back jobs");
    fillVectors(3);
    applyStimulus(1'b0, 1'b0, 1'b1, lat, f1, held);
    checkOutput("b2b1_max", int'(m_max), 2);
    checkOutput("b2b1_pos_ref", int'(m_pr), 10);
    checkOutput("b2b1_pos_query", int'(m_pq), 5);
    fillVectors(2);
    applyStimulus(1'b0, 1'b0, 1'b1, lat, f2, held);
    checkOutput("b2b2_held", held, 2);
    checkOutput("b2b2_max", int'(m_max), 0);
    checkOutput("b2b2_pos_ref", int'(m_pr), 0);
    checkOutput("b2b2_pos_query", int'(m_pq), 0);
    checkOutput("b2b2_latency", lat, T_CAL0 + 1);
    checkOutput("b2b_period", f2 - f1, 64 + T_CAL0 + 2);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, fail_count);
    $finish;
  end

endmodule
